// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm bank: FSM encodings, edit field codes,
// BCD time layout and the wrapping BCD increment.
package alarm_pkg;

  localparam int BCD_W  = 4;
  localparam int TIME_W = 6 * BCD_W;
  localparam int CNT_W  = 12;

  localparam logic [1:0] ST_DISABLED = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_RINGING  = 2'd2;
  localparam logic [1:0] ST_SNOOZED  = 2'd3;

  localparam logic [1:0] FIELD_SEC  = 2'd0;
  localparam logic [1:0] FIELD_MIN  = 2'd1;
  localparam logic [1:0] FIELD_HOUR = 2'd2;
  localparam logic [1:0] FIELD_NONE = 2'd3;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } bcd_time_t;

  // Two-digit BCD increment that wraps to 00 after max_val.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max_val);
    if (val == max_val) return 8'h00;
    if (val[3:0] == 4'd9) return {val[7:4] + 4'd1, 4'd0};
    return {val[7:4], val[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: BCD alarm time, enable/ring/snooze FSM and counters.
// Optional ring timeout is built when ALARM_TIMEOUT_EN is defined.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int SNOOZE_SECS = 300,
  parameter int RING_SECS   = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sec_tick_i,
  input  logic              match_tick_i,
  input  logic [TIME_W-1:0] cur_time_i,
  input  logic              inc_i,
  input  logic [1:0]        field_i,
  input  logic              en_toggle_i,
  input  logic              ack_i,
  input  logic              snooze_i,
  output logic [TIME_W-1:0] time_o,
  output logic [1:0]        state_o
);

  if (SNOOZE_SECS < 1 || SNOOZE_SECS > 4095 || RING_SECS < 1 || RING_SECS > 4095) begin : g_param_check
    $error("alarm_channel: SNOOZE_SECS and RING_SECS must lie in 1..4095");
  end

  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SECS);

  bcd_time_t        time_q, time_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] snz_cnt_q, snz_cnt_d;
  logic             match;
  logic             ring_expired;

  // The comparison sees time_q before any edit landing on the same edge.
  assign match = match_tick_i && (state_q == ST_ARMED) && (cur_time_i == time_q);

`ifdef ALARM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] RING_LOAD = CNT_W'(RING_SECS);
  logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;

  assign ring_expired = sec_tick_i && (ring_cnt_q <= CNT_W'(1));

  always_comb begin
    ring_cnt_d = ring_cnt_q;
    if (state_d == ST_RINGING && state_q != ST_RINGING) ring_cnt_d = RING_LOAD;
    else if (state_d != ST_RINGING)                     ring_cnt_d = '0;
    else if (sec_tick_i)                                ring_cnt_d = ring_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ring_cnt_q <= '0;
    else        ring_cnt_q <= ring_cnt_d;
  end
`else
  assign ring_expired = 1'b0;
`endif

  always_comb begin
    // NOTE: every target gets a default first, so no path through this block infers a latch.
    time_d    = time_q;
    state_d   = state_q;
    snz_cnt_d = snz_cnt_q;

    if (inc_i) begin
      case (field_i)
        FIELD_SEC:  time_d.sec  = bcd_inc(time_q.sec, SEC_MAX);
        FIELD_MIN:  time_d.min  = bcd_inc(time_q.min, MIN_MAX);
        FIELD_HOUR: time_d.hour = bcd_inc(time_q.hour, HOUR_MAX);
        default:    ;
      endcase
    end

    if (en_toggle_i) begin
      state_d   = (state_q == ST_DISABLED) ? ST_ARMED : ST_DISABLED;
      snz_cnt_d = '0;
    end else begin
      case (state_q)
        ST_ARMED: if (match) state_d = ST_RINGING;
        ST_RINGING: begin
          if (ack_i) begin
            state_d = ST_ARMED;
          end else if (snooze_i) begin
            state_d   = ST_SNOOZED;
            snz_cnt_d = SNOOZE_LOAD;
          end else if (ring_expired) begin
            state_d = ST_ARMED;
          end
        end
        ST_SNOOZED: begin
          if (ack_i) begin
            state_d   = ST_ARMED;
            snz_cnt_d = '0;
          end else if (sec_tick_i) begin
            if (snz_cnt_q <= CNT_W'(1)) begin
              state_d   = ST_RINGING;
              snz_cnt_d = '0;
            end else begin
              snz_cnt_d = snz_cnt_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the alarm time registers are reset like any other state so a fresh
  // power-up never presents a random alarm time that could match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      time_q    <= '0;
      state_q   <= ST_DISABLED;
      snz_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      time_q    <= time_d;
      state_q   <= state_d;
      snz_cnt_q <= snz_cnt_d;
    end
  end

  assign time_o  = time_q;
  assign state_o = state_q;

endmodule

// File: rtl/alarm_bank.sv
// Multi-alarm manager: sel decode, lowest-index ack/snooze arbitration and
// registered status outputs. Optional ring timeout: ALARM_TIMEOUT_EN.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS  = 4,
  parameter int SEL_W       = 2,
  parameter int SNOOZE_SECS = 300,
  parameter int RING_SECS   = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sec_tick,
  input  logic [TIME_W-1:0]     cur_time,
  input  logic [SEL_W-1:0]      sel,
  input  logic [1:0]            field,
  input  logic                  inc,
  input  logic                  en_toggle,
  input  logic                  ack,
  input  logic                  snooze,
  output logic [TIME_W-1:0]     sel_time,
  output logic [NUM_ALARMS-1:0] enabled,
  output logic                  ringing,
  output logic [SEL_W-1:0]      ring_id,
  output logic [NUM_ALARMS-1:0] snoozed
);

  if (NUM_ALARMS < 1 || NUM_ALARMS > 16 || (1 << SEL_W) < NUM_ALARMS) begin : g_param_check
    $error("alarm_bank: need 1 <= NUM_ALARMS <= 16 and 2**SEL_W >= NUM_ALARMS");
  end

  logic                  sec_tick_d1_q;
  logic [TIME_W-1:0]     ch_time  [NUM_ALARMS];
  logic [1:0]            ch_state [NUM_ALARMS];

  logic [NUM_ALARMS-1:0] ring_vec, snz_vec, inc_vec, en_vec, ack_vec, snooze_vec;
  logic [SEL_W-1:0]      ring_idx, snz_idx;

  logic [TIME_W-1:0]     sel_time_q, sel_time_d;
  logic [NUM_ALARMS-1:0] enabled_q, enabled_d;
  logic [NUM_ALARMS-1:0] snoozed_q;
  logic                  ringing_q;
  logic [SEL_W-1:0]      ring_id_q;

  always_comb begin
    ring_vec = '0;
    snz_vec  = '0;
    inc_vec  = '0;
    en_vec   = '0;
    enabled_d = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      ring_vec[i]  = (ch_state[i] == ST_RINGING);
      snz_vec[i]   = (ch_state[i] == ST_SNOOZED);
      enabled_d[i] = (ch_state[i] != ST_DISABLED);
      inc_vec[i]   = inc && (sel == SEL_W'(i));
      en_vec[i]    = en_toggle && (sel == SEL_W'(i));
    end
  end

  // Walk downwards so the lowest index is the last (winning) assignment.
  always_comb begin
    ring_idx = '0;
    snz_idx  = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (ring_vec[i]) ring_idx = SEL_W'(i);
      if (snz_vec[i])  snz_idx  = SEL_W'(i);
    end
  end

  // While anything rings, ack/snooze target the ringing winner; otherwise ack
  // may release the lowest snoozed channel. ack beats snooze.
  always_comb begin
    ack_vec    = '0;
    snooze_vec = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (|ring_vec) begin
        ack_vec[i]    = ack && (ring_idx == SEL_W'(i));
        snooze_vec[i] = snooze && !ack && (ring_idx == SEL_W'(i));
      end else begin
        ack_vec[i] = ack && (|snz_vec) && (snz_idx == SEL_W'(i));
      end
    end
  end

  always_comb begin
    sel_time_d = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (sel == SEL_W'(i)) sel_time_d = ch_time[i];
    end
  end

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
    alarm_channel #(
      .SNOOZE_SECS (SNOOZE_SECS),
      .RING_SECS   (RING_SECS)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .sec_tick_i   (sec_tick),
      .match_tick_i (sec_tick_d1_q),
      .cur_time_i   (cur_time),
      .inc_i        (inc_vec[g]),
      .field_i      (field),
      .en_toggle_i  (en_vec[g]),
      .ack_i        (ack_vec[g]),
      .snooze_i     (snooze_vec[g]),
      .time_o       (ch_time[g]),
      .state_o      (ch_state[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_tick_d1_q <= 1'b0;
      sel_time_q    <= '0;
      enabled_q     <= '0;
      snoozed_q     <= '0;
      ringing_q     <= 1'b0;
      ring_id_q     <= '0;
    end else begin
      sec_tick_d1_q <= sec_tick;
      sel_time_q    <= sel_time_d;
      enabled_q     <= enabled_d;
      snoozed_q     <= snz_vec;
      ringing_q     <= |ring_vec;
      ring_id_q     <= ring_idx;
    end
  end

  assign sel_time = sel_time_q;
  assign enabled  = enabled_q;
  assign snoozed  = snoozed_q;
  assign ringing  = ringing_q;
  assign ring_id  = ring_id_q;

endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
- Parametrised multi-alarm manager; successor to the single alarm_counter plus alarm state machine pair.
- Holds NUM_ALARMS independent BCD alarm times (HH:MM:SS), each with its own enable, ring, snooze and timeout state machine.
- Compares each alarm against the current-time counter once per second.
- Sits between the time counter and the keyboard/VGA logic; drives a single ringing indication and per-alarm status to the display section.

Parameters:
- NUM_ALARMS, 4, number of alarm channels (1..16)
- SEL_W, 2, width of alarm select (must satisfy 2**SEL_W >= NUM_ALARMS)
- SNOOZE_SECS, 300, seconds spent snoozed before re-ringing (1..4095)
- RING_SECS, 60, seconds of ringing before auto-acknowledge (1..4095); used only with ALARM_TIMEOUT_EN

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sec_tick  in  1  one-clk pulse per second, clk domain
- cur_time  in  24  current time, BCD {hMSB,hLSB,mMSB,mLSB,sMSB,sLSB}, 4 bits each
- sel  in  SEL_W  alarm being edited or queried
- field  in  2  field to edit: 0 = sec, 1 = min, 2 = hour, 3 = none
- inc  in  1  one-clk pulse; increments the selected field of alarm sel
- en_toggle  in  1  one-clk pulse; toggles the enable of alarm sel
- ack  in  1  one-clk pulse; acknowledges the active alarm
- snooze  in  1  one-clk pulse; snoozes the active alarm
- sel_time  out  24  BCD time of alarm sel (registered)
- enabled  out  NUM_ALARMS  per-alarm enable (state != DISABLED)
- ringing  out  1  OR of all channels in RINGING
- ring_id  out  SEL_W  lowest-index channel in RINGING; 0 when none
- snoozed  out  NUM_ALARMS  per-alarm SNOOZED flag

Behaviour:
- Reset (reset=0, asynchronous):
  - All alarm times 00:00:00; all channels DISABLED.
  - All counters 0; every output 0.
- Per-channel FSM states:
  - DISABLED -> ARMED on en_toggle (sel = this channel).
  - ARMED -> RINGING on match.
  - RINGING -> ARMED on ack.
  - RINGING -> SNOOZED on snooze. Loads the snooze counter with SNOOZE_SECS.
  - SNOOZED -> RINGING when the snooze counter reaches 0. The counter decrements on sec_tick.
  - SNOOZED -> ARMED on ack.
  - Any state -> DISABLED on en_toggle (sel = this channel); counters are cleared.
- Match: evaluated in the cycle after sec_tick, using the registered sec_tick_d1 so the counter output has settled.
  - Match means cur_time == alarm time AND state == ARMED.
  - State becomes RINGING on the following clk edge.
  - Several channels may match at the same time; all of them enter RINGING.
- ack and snooze apply only to the channel at ring_id, and only while ringing=1.
  - While SNOOZED and nothing is ringing, ack applies to the lowest-index SNOOZED channel.
  - ack and snooze in the same cycle: ack wins.
  - ack or snooze with no eligible channel: ignored.
- Edit (inc with field 0/1/2):
  - Increments in BCD with wrap: sec 59->00, min 59->00, hour 23->00. No carry into the next field.
  - field 3: no change.
  - Edits are allowed in any state and do not change FSM state.
  - An edit in the same cycle as a match: the match uses the pre-edit value.
- sel >= NUM_ALARMS: inc and en_toggle are ignored; sel_time reads 0.
- Latency:
  - sel_time is valid 1 clk after a change of sel or an edit.
  - ringing, ring_id, enabled and snoozed are registered, 1 clk after the state change.
- Snoozed channel that is re-disabled and re-enabled: returns to ARMED with the snooze counter cleared.

Optional Feature:
- ALARM_TIMEOUT_EN defined:
  - Each channel has a ring counter, loaded with RING_SECS on entry to RINGING and decremented on sec_tick.
  - At 0 the channel auto-acknowledges to ARMED.
  - A snooze followed by a re-ring reloads the counter.
- ALARM_TIMEOUT_EN undefined: no ring counter; RINGING persists until ack or snooze.

Decomposition:
- Shared package alarm_pkg:
  - FSM state encodings: DISABLED, ARMED, RINGING, SNOOZED.
  - Field codes FIELD_SEC, FIELD_MIN, FIELD_HOUR, FIELD_NONE.
  - BCD digit width of 4; time word width of 24.
  - BCD wrap limits for seconds/minutes (59) and hours (23).
- Sub-module alarm_channel, instantiated NUM_ALARMS times via generate:
  - Holds the time registers, the BCD increment, the FSM and the snooze/ring counters.
- alarm_bank contains sel decode, ack/snooze arbitration (lowest index wins), and output muxing/registers.

Test Plan:
- Reset, then sel=1, field=1, inc x3, field=2, inc x7, en_toggle -> sel_time=07:03:00, enabled=4'b0010.
- Alarm1 at 07:03:00 enabled; drive cur_time 07:02:59 then 07:03:00 with sec_tick -> ringing=1, ring_id=1, 2 clks after the second tick.
- Alarms 0 and 2 both set to 12:00:00 and enabled; match -> ringing=1, ring_id=0. ack -> ring_id=2. ack -> ringing=0, enabled=4'b0101.
- SNOOZE_SECS=3, alarm ringing; snooze -> snoozed[id]=1, ringing=0. After 3 sec_ticks -> ringing=1 again. Same-cycle ack+snooze -> ARMED, snoozed=0.
- Edit wrap: alarm hour at 23, inc -> 00; sec at 59, inc -> 00 with minutes unchanged. sel=3 with NUM_ALARMS=3, inc -> no change, sel_time=0.
- ALARM_TIMEOUT_EN with RING_SECS=2: ring, no ack, 2 sec_ticks -> ringing=0, channel ARMED. Assert reset mid-ring -> all outputs 0 immediately.
